ex2_mem_access_unit: RTL and testbench

//   Load/store/AMO sequencer in the memory-access stage, directly downstream of the EX2 pipeline register.

---
 rtl/ex2_mem_access_unit.sv | 254 +++++++++++++++++++++++++
 tb/tb_ex2_mem_access_unit.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/ex2_mem_access_unit.sv
// ex2_mem_access_unit
//   Memory-access stage sequencer that sits after the EX2 pipeline register.
//   It turns EX2 load, store and AMO requests into single-beat data-bus
//   transactions, aligns and extends load data, runs read-modify-write for
//   AMOs, and holds the pipeline until the access completes.
// Ports
//   clk, rstn           clock; synchronous reset, active high (1 = reset)
//   flush               drops a request that has not been granted yet
//   rd_en/wr_en/is_amo  request type from EX2 (an AMO sets rd_en and wr_en)
//   amo_op, len         AMO operation (swap/add/and/or/xor) and access size
//   ld_unsigned         zero-extend the load result
//   addr, wdata         effective address and LSB-justified store operand
//   dbus_*              request/grant/response data-bus interface
//   lsu_hold            stall for EX2 and all earlier stages
//   ld_valid, ld_data   one-cycle load result (the old memory value for an AMO)
//   misalign            one-cycle pulse for a misaligned request (no bus traffic)
module ex2_mem_access_unit #(
  parameter int XLEN   = 64,
  parameter int ADDR_W = 64
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              flush,
  input  logic              rd_en,
  input  logic              wr_en,
  input  logic              is_amo,
  input  logic [2:0]        amo_op,
  input  logic [1:0]        len,
  input  logic              ld_unsigned,
  input  logic [ADDR_W-1:0] addr,
  input  logic [XLEN-1:0]   wdata,
  output logic              dbus_req,
  output logic              dbus_we,
  output logic [ADDR_W-1:0] dbus_addr,
  output logic [XLEN-1:0]   dbus_wdata,
  output logic [XLEN/8-1:0] dbus_wstrb,
  input  logic              dbus_gnt,
  input  logic              dbus_rvalid,
  input  logic [XLEN-1:0]   dbus_rdata,
  output logic              lsu_hold,
  output logic              ld_valid,
  output logic [XLEN-1:0]   ld_data,
  output logic              misalign
);

  localparam int NB = XLEN / 8;
  localparam int SW = $clog2(NB);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_RREQ  = 3'd1;
  localparam logic [2:0] S_RWAIT = 3'd2;
  localparam logic [2:0] S_WREQ  = 3'd3;
  localparam logic [2:0] S_WWAIT = 3'd4;

  // Keep the low (8 << l) bits of v; fill the rest with zeros or the sign bit.
  function automatic logic [XLEN-1:0] fit_len(input logic [XLEN-1:0] v,
                                              input logic [1:0] l,
                                              input logic uns);
    logic [XLEN-1:0] r;
    int nbits;
    logic sb;
    nbits = 8 << l;
    if (nbits > XLEN) nbits = XLEN;
    sb = uns ? 1'b0 : v[nbits-1];
    for (int i = 0; i < XLEN; i++) r[i] = (i < nbits) ? v[i] : sb;
    return r;
  endfunction

  // Unshifted byte-strobe pattern for an access of (1 << l) bytes.
  function automatic logic [NB-1:0] len_strb(input logic [1:0] l);
    logic [NB-1:0] r;
    for (int i = 0; i < NB; i++) r[i] = (i < (1 << l));
    return r;
  endfunction

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [XLEN-1:0]   wdata_q, wdata_d;
  logic [1:0]        len_q, len_d;
  logic [2:0]        amo_op_q, amo_op_d;
  logic              uns_q, uns_d;
  logic              amo_q, amo_d;
  logic              kill_q, kill_d;
  logic [XLEN-1:0]   old_q, old_d;
  logic              ld_valid_q, ld_valid_d;
  logic [XLEN-1:0]   ld_data_q, ld_data_d;
  logic              misalign_q, misalign_d;

  logic              req_s, mis_s, accept_s;
  logic [3:0]        amask_s;
  logic [SW-1:0]     shift_s;
  logic [XLEN-1:0]   lane_s, ld_ext_s, amo_new_s, amo_old_s, amo_opnd_s, amo_raw_s;

  // Request decode, alignment check and load-lane extraction.
  always_comb begin
    req_s     = rd_en | wr_en;
    amask_s   = (4'd1 << len) - 4'd1;
    mis_s     = (|(addr[2:0] & amask_s[2:0])) | ((XLEN == 32) && (len == 2'd3));
    shift_s   = addr_q[SW-1:0];
    lane_s    = dbus_rdata >> {shift_s, 3'b000};
    // AMO results are always sign-extended into ld_data.
    ld_ext_s  = fit_len(lane_s, len_q, uns_q & ~amo_q);
  end

  // AMO arithmetic on len-sized operands; the result wraps at the access size.
  always_comb begin
    amo_old_s  = fit_len(lane_s, len_q, 1'b1);
    amo_opnd_s = fit_len(wdata_q, len_q, 1'b1);
    case (amo_op_q)
      3'd1:    amo_raw_s = amo_old_s + amo_opnd_s;
      3'd2:    amo_raw_s = amo_old_s & amo_opnd_s;
      3'd3:    amo_raw_s = amo_old_s | amo_opnd_s;
      3'd4:    amo_raw_s = amo_old_s ^ amo_opnd_s;
      default: amo_raw_s = amo_opnd_s;
    endcase
    amo_new_s = fit_len(amo_raw_s, len_q, 1'b1);
  end

  // Sequencer next state and operand capture.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    len_d      = len_q;
    amo_op_d   = amo_op_q;
    uns_d      = uns_q;
    amo_d      = amo_q;
    kill_d     = kill_q;
    old_d      = old_q;
    ld_data_d  = ld_data_q;
    ld_valid_d = 1'b0;
    misalign_d = 1'b0;
    accept_s   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_s && !flush) begin
          if (mis_s) begin
            misalign_d = 1'b1;
          end else begin
            accept_s = 1'b1;
            addr_d   = addr;
            wdata_d  = wdata;
            len_d    = len;
            amo_op_d = amo_op;
            uns_d    = ld_unsigned;
            amo_d    = is_amo & rd_en;
            kill_d   = 1'b0;
            old_d    = {XLEN{1'b0}};
            state_d  = rd_en ? S_RREQ : S_WREQ;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RREQ, S_WREQ: begin
        if (dbus_gnt) begin
          // Once granted the beat must finish on the bus; a flush only discards it.
          state_d = (state_q == S_RREQ) ? S_RWAIT : S_WWAIT;
          kill_d  = kill_q | flush;
        end else if (flush) begin
          state_d = S_IDLE;
        end else begin
          state_d = state_q;
        end
      end
      S_RWAIT: begin
        kill_d = kill_q | flush;
        if (dbus_rvalid) begin
          if (amo_q) begin
            old_d   = ld_ext_s;
            wdata_d = amo_new_s;
            state_d = S_WREQ;
          end else begin
            state_d    = S_IDLE;
            ld_valid_d = ~(kill_q | flush);
            ld_data_d  = (kill_q | flush) ? ld_data_q : ld_ext_s;
          end
        end else begin
          state_d = S_RWAIT;
        end
      end
      S_WWAIT: begin
        kill_d = kill_q | flush;
        if (dbus_rvalid) begin
          state_d = S_IDLE;
          if (amo_q && !(kill_q || flush)) begin
            ld_valid_d = 1'b1;
            ld_data_d  = old_q;
          end else begin
            ld_valid_d = 1'b0;
          end
        end else begin
          state_d = S_WWAIT;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Bus and stall outputs decoded from the current state.
  always_comb begin
    dbus_req = (state_q == S_RREQ) || (state_q == S_WREQ);
    dbus_we  = (state_q == S_WREQ);
    lsu_hold = (state_q != S_IDLE) || accept_s;
    if (dbus_req) begin
      dbus_addr = {addr_q[ADDR_W-1:SW], {SW{1'b0}}};
    end else begin
      dbus_addr = {ADDR_W{1'b0}};
    end
    if (dbus_we) begin
      dbus_wdata = wdata_q << {shift_s, 3'b000};
      dbus_wstrb = len_strb(len_q) << shift_s;
    end else begin
      dbus_wdata = {XLEN{1'b0}};
      dbus_wstrb = {NB{1'b0}};
    end
  end

  assign ld_valid = ld_valid_q;
  assign ld_data  = ld_data_q;
  assign misalign = misalign_q;

  // State and operand registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rstn) begin
      state_q    <= S_IDLE;
      addr_q     <= {ADDR_W{1'b0}};
      wdata_q    <= {XLEN{1'b0}};
      len_q      <= 2'd0;
      amo_op_q   <= 3'd0;
      uns_q      <= 1'b0;
      amo_q      <= 1'b0;
      kill_q     <= 1'b0;
      old_q      <= {XLEN{1'b0}};
      ld_valid_q <= 1'b0;
      ld_data_q  <= {XLEN{1'b0}};
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      len_q      <= len_d;
      amo_op_q   <= amo_op_d;
      uns_q      <= uns_d;
      amo_q      <= amo_d;
      kill_q     <= kill_d;
      old_q      <= old_d;
      ld_valid_q <= ld_valid_d;
      ld_data_q  <= ld_data_d;
      misalign_q <= misalign_d;
    end
  end

endmodule

// File: tb/tb_ex2_mem_access_unit.sv
// Bench for ex2_mem_access_unit: directed cases plus randomized loads, stores
// and AMOs checked against a byte-level memory model.
module tb_ex2_mem_access_unit;

  logic        clk = 1'b0;
  logic        rstn, flush, rd_en, wr_en, is_amo, ld_unsigned;
  logic [2:0]  amo_op;
  logic [1:0]  len;
  logic [63:0] addr, wdata;
  logic        dbus_req, dbus_we, dbus_gnt, dbus_rvalid;
  logic [63:0] dbus_addr, dbus_wdata, dbus_rdata;
  logic [7:0]  dbus_wstrb;
  logic        lsu_hold, ld_valid, misalign;
  logic [63:0] ld_data;

  always #5 clk = ~clk;

  ex2_mem_access_unit dut (
    .clk(clk), .rstn(rstn), .flush(flush), .rd_en(rd_en), .wr_en(wr_en),
    .is_amo(is_amo), .amo_op(amo_op), .len(len), .ld_unsigned(ld_unsigned),
    .addr(addr), .wdata(wdata), .dbus_req(dbus_req), .dbus_we(dbus_we),
    .dbus_addr(dbus_addr), .dbus_wdata(dbus_wdata), .dbus_wstrb(dbus_wstrb),
    .dbus_gnt(dbus_gnt), .dbus_rvalid(dbus_rvalid), .dbus_rdata(dbus_rdata),
    .lsu_hold(lsu_hold), .ld_valid(ld_valid), .ld_data(ld_data), .misalign(misalign)
  );

  logic [63:0] bus_mem [32];
  logic [63:0] ref_mem [32];
  int n_cmp = 0;
  int n_err = 0;

  int          o_hold, o_lv, o_mis, o_req, o_wgnt;
  logic [63:0] o_ld_data, o_raddr, o_waddr, o_wdata;
  logic [7:0]  o_wstrb;
  logic        o_zero;

  // Drive one request and act as the bus for 16 cycles, recording what happens.
  task automatic run_op(input logic rd, input logic wr, input logic amo,
                        input logic [2:0] op, input logic [1:0] l, input logic uns,
                        input logic [63:0] a, input logic [63:0] wd,
                        input int gdly, input int rdly, input int flush_cyc, input int rst_cyc);
    int wait_c;
    int cd;
    logic pend_we;
    logic [4:0] pidx;
    o_hold = 0; o_lv = 0; o_mis = 0; o_req = 0; o_wgnt = 0; o_zero = 1'b0;
    o_ld_data = 64'd0; o_raddr = 64'd0; o_waddr = 64'd0; o_wdata = 64'd0; o_wstrb = 8'd0;
    wait_c = 0; cd = 0; pend_we = 1'b0; pidx = 5'd0;
    @(posedge clk); #1;
    rd_en = rd; wr_en = wr; is_amo = amo; amo_op = op; len = l;
    ld_unsigned = uns; addr = a; wdata = wd;
    for (int c = 0; c < 16; c++) begin
      flush = (c == flush_cyc);
      rstn  = (c == rst_cyc);
      @(negedge clk);
      if (lsu_hold) o_hold++;
      if (ld_valid) begin o_lv++; o_ld_data = ld_data; end
      if (misalign) o_mis++;
      if (dbus_req) o_req++;
      if (c == rst_cyc + 1)
        o_zero = !(dbus_req | dbus_we | lsu_hold | ld_valid | misalign) &&
                 dbus_addr == 64'd0 && dbus_wdata == 64'd0 && dbus_wstrb == 8'd0 && ld_data == 64'd0;
      if (cd > 0) begin
        cd--;
        if (cd == 0) begin
          dbus_rvalid = 1'b1;
          dbus_rdata  = pend_we ? {$urandom, $urandom} : bus_mem[pidx];
        end
      end
      if (dbus_req) begin
        if (wait_c >= gdly) begin
          dbus_gnt = 1'b1; wait_c = 0; cd = rdly;
          pend_we = dbus_we; pidx = dbus_addr[7:3];
          if (dbus_we) begin
            o_wgnt++; o_wdata = dbus_wdata; o_wstrb = dbus_wstrb; o_waddr = dbus_addr;
            for (int b = 0; b < 8; b++)
              if (dbus_wstrb[b]) bus_mem[pidx][8*b +: 8] = dbus_wdata[8*b +: 8];
          end else begin
            o_raddr = dbus_addr;
          end
        end else begin
          wait_c++;
        end
      end
      @(posedge clk); #1;
      rd_en = 1'b0; wr_en = 1'b0; is_amo = 1'b0; dbus_gnt = 1'b0;
      dbus_rvalid = 1'b0; flush = 1'b0; rstn = 1'b0;
    end
  endtask

  // Reference: memory as bytes, access of 2**l bytes at a, result extended.
  task automatic model(input logic rd, input logic wr, input logic amo, input logic [2:0] op,
                       input logic [1:0] l, input logic uns, input logic [63:0] a,
                       input logic [63:0] wd, output logic e_mis, output int e_lv,
                       output logic [63:0] e_ld);
    int nbytes;
    int sh;
    logic [63:0] m, old, nv;
    nbytes = 1 << l;
    e_mis = (a % nbytes) != 0;
    e_lv = 0; e_ld = 64'd0;
    if (e_mis) return;
    sh = a % 8;
    m = (nbytes == 8) ? ~64'd0 : ((64'd1 << (8 * nbytes)) - 64'd1);
    old = (ref_mem[a[7:3]] >> (8 * sh)) & m;
    e_ld = ((!uns || amo) && old[8 * nbytes - 1]) ? (old | ~m) : old;
    if (amo) begin
      case (op)
        3'd1: nv = old + wd;
        3'd2: nv = old & wd;
        3'd3: nv = old | wd;
        3'd4: nv = old ^ wd;
        default: nv = wd;
      endcase
      e_lv = 1;
    end else if (rd) begin
      nv = 64'd0;
      e_lv = 1;
    end else begin
      nv = wd;
    end
    if (wr) ref_mem[a[7:3]] = (ref_mem[a[7:3]] & ~(m << (8 * sh))) | ((nv & m) << (8 * sh));
  endtask

  task automatic test_reset();
    rstn = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (dbus_req !== 1'b0 || dbus_we !== 1'b0) begin n_err++; $display("FAIL reset_req: req %b we %b want 0", dbus_req, dbus_we); end
    n_cmp++; if (lsu_hold !== 1'b0 || ld_valid !== 1'b0 || misalign !== 1'b0) begin n_err++; $display("FAIL reset_ctl: hold %b lv %b mis %b want 0", lsu_hold, ld_valid, misalign); end
    n_cmp++; if ({dbus_addr, dbus_wdata, dbus_wstrb, ld_data} !== 200'd0) begin n_err++; $display("FAIL reset_data: addr %h wdata %h strb %h ld %h want 0", dbus_addr, dbus_wdata, dbus_wstrb, ld_data); end
    @(posedge clk); #1;
    rstn = 1'b0;
  endtask

  task automatic test_load_word();
    bus_mem[0] = 64'h8000_0001_1234_5678; ref_mem[0] = bus_mem[0];
    run_op(1'b1, 1'b0, 1'b0, 3'd0, 2'd2, 1'b0, 64'h1004, 64'd0, 0, 1, -1, -1);
    n_cmp++; if (o_ld_data !== 64'hFFFF_FFFF_8000_0001) begin n_err++; $display("FAIL lw_data: got %h want ffffffff80000001", o_ld_data); end
    n_cmp++; if (o_lv !== 1) begin n_err++; $display("FAIL lw_pulses: got %0d want 1", o_lv); end
    n_cmp++; if (o_hold !== 3) begin n_err++; $display("FAIL lw_hold: got %0d want 3", o_hold); end
    n_cmp++; if (o_raddr !== 64'h1000) begin n_err++; $display("FAIL lw_addr: got %h want 1000", o_raddr); end
  endtask

  task automatic test_store_half();
    logic e_mis; int e_lv; logic [63:0] e_ld;
    model(1'b0, 1'b1, 1'b0, 3'd0, 2'd1, 1'b0, 64'h2002, 64'hBEEF, e_mis, e_lv, e_ld);
    run_op(1'b0, 1'b1, 1'b0, 3'd0, 2'd1, 1'b0, 64'h2002, 64'hBEEF, 1, 1, -1, -1);
    n_cmp++; if (o_wstrb !== 8'h0C) begin n_err++; $display("FAIL sh_strb: got %h want 0c", o_wstrb); end
    n_cmp++; if (o_wdata[31:16] !== 16'hBEEF) begin n_err++; $display("FAIL sh_wdata: got %h want beef", o_wdata[31:16]); end
    n_cmp++; if (o_wgnt !== 1 || o_lv !== 0) begin n_err++; $display("FAIL sh_beat: writes %0d lv %0d want 1 0", o_wgnt, o_lv); end
    n_cmp++; if (bus_mem[0] !== ref_mem[0]) begin n_err++; $display("FAIL sh_mem: got %h want %h", bus_mem[0], ref_mem[0]); end
  endtask

  task automatic test_misalign();
    run_op(1'b1, 1'b0, 1'b0, 3'd0, 2'd1, 1'b0, 64'h3001, 64'd0, 0, 1, -1, -1);
    n_cmp++; if (o_mis !== 1) begin n_err++; $display("FAIL lh_mis: got %0d want 1", o_mis); end
    n_cmp++; if (o_req !== 0 || o_hold !== 0) begin n_err++; $display("FAIL lh_quiet: req %0d hold %0d want 0 0", o_req, o_hold); end
    run_op(1'b0, 1'b1, 1'b0, 3'd0, 2'd3, 1'b0, 64'h3004, 64'd1, 0, 1, -1, -1);
    n_cmp++; if (o_mis !== 1 || o_req !== 0) begin n_err++; $display("FAIL sd_mis: mis %0d req %0d want 1 0", o_mis, o_req); end
  endtask

  task automatic test_amo_add();
    bus_mem[8] = 64'd5; ref_mem[8] = 64'd5;
    run_op(1'b1, 1'b1, 1'b1, 3'd1, 2'd3, 1'b0, 64'h40, 64'd7, 0, 1, -1, -1);
    n_cmp++; if (bus_mem[8] !== 64'd12) begin n_err++; $display("FAIL amo_mem: got %h want c", bus_mem[8]); end
    n_cmp++; if (o_wstrb !== 8'hFF) begin n_err++; $display("FAIL amo_strb: got %h want ff", o_wstrb); end
    n_cmp++; if (o_ld_data !== 64'd5 || o_lv !== 1) begin n_err++; $display("FAIL amo_ld: got %h (%0d pulses) want 5 (1)", o_ld_data, o_lv); end
    n_cmp++; if (o_hold !== 5) begin n_err++; $display("FAIL amo_hold: got %0d want 5", o_hold); end
    ref_mem[8] = 64'd12;
  endtask

  task automatic test_flush();
    run_op(1'b1, 1'b0, 1'b0, 3'd0, 2'd3, 1'b0, 64'h1008, 64'd0, 5, 1, 1, -1);
    n_cmp++; if (o_lv !== 0 || o_req !== 1 || o_hold !== 2) begin n_err++; $display("FAIL flush_rreq: lv %0d req %0d hold %0d want 0 1 2", o_lv, o_req, o_hold); end
    run_op(1'b1, 1'b0, 1'b0, 3'd0, 2'd3, 1'b0, 64'h1008, 64'd0, 0, 2, 2, -1);
    n_cmp++; if (o_lv !== 0 || o_hold !== 4) begin n_err++; $display("FAIL flush_rwait: lv %0d hold %0d want 0 4", o_lv, o_hold); end
  endtask

  task automatic test_reset_mid();
    run_op(1'b1, 1'b0, 1'b0, 3'd0, 2'd3, 1'b0, 64'h1010, 64'd0, 0, 3, -1, 2);
    n_cmp++; if (o_zero !== 1'b1) begin n_err++; $display("FAIL rst_rwait_outputs: got %b want 1", o_zero); end
    n_cmp++; if (o_lv !== 0) begin n_err++; $display("FAIL rst_late_rvalid: lv %0d want 0", o_lv); end
  endtask

  task automatic test_random();
    logic rd, wr, amo, uns, e_mis; logic [2:0] op; logic [1:0] l;
    logic [63:0] a, wd, e_ld; int kind, gd, rv, e_lv, e_hold;
    for (int n = 0; n < 60; n++) begin
      kind = $urandom_range(0, 2);
      rd = (kind != 1); wr = (kind != 0); amo = (kind == 2);
      op = 3'($urandom_range(0, 4)); l = 2'($urandom_range(0, 3)); uns = 1'($urandom);
      a = {32'd0, $urandom};
      if ($urandom_range(0, 3) != 0) a = a & ~((64'd1 << l) - 64'd1);
      wd = {$urandom, $urandom};
      gd = $urandom_range(0, 2); rv = $urandom_range(1, 3);
      model(rd, wr, amo, op, l, uns, a, wd, e_mis, e_lv, e_ld);
      e_hold = e_mis ? 0 : ((amo ? 2 : 1) * (1 + gd + rv) + 1);
      run_op(rd, wr, amo, op, l, uns, a, wd, gd, rv, -1, -1);
      n_cmp++; if (o_mis !== int'(e_mis)) begin n_err++; $display("FAIL rnd%0d_mis: got %0d want %0d", n, o_mis, e_mis); end
      n_cmp++; if (o_lv !== e_lv) begin n_err++; $display("FAIL rnd%0d_lv: got %0d want %0d", n, o_lv, e_lv); end
      n_cmp++; if (e_lv == 1 && o_ld_data !== e_ld) begin n_err++; $display("FAIL rnd%0d_ld: got %h want %h", n, o_ld_data, e_ld); end
      n_cmp++; if (o_hold !== e_hold) begin n_err++; $display("FAIL rnd%0d_hold: got %0d want %0d", n, o_hold, e_hold); end
      n_cmp++; if (bus_mem[a[7:3]] !== ref_mem[a[7:3]]) begin n_err++; $display("FAIL rnd%0d_mem: got %h want %h", n, bus_mem[a[7:3]], ref_mem[a[7:3]]); end
      n_cmp++; if (!e_mis && (rd ? o_raddr : o_waddr) !== (a & ~64'd7)) begin n_err++; $display("FAIL rnd%0d_addr: got %h want %h", n, rd ? o_raddr : o_waddr, a & ~64'd7); end
    end
  endtask

  initial begin
    rstn = 1'b1; flush = 1'b0; rd_en = 1'b0; wr_en = 1'b0; is_amo = 1'b0;
    amo_op = 3'd0; len = 2'd0; ld_unsigned = 1'b0; addr = 64'd0; wdata = 64'd0;
    dbus_gnt = 1'b0; dbus_rvalid = 1'b0; dbus_rdata = 64'd0;
    for (int i = 0; i < 32; i++) begin
      bus_mem[i] = {$urandom, $urandom};
      ref_mem[i] = bus_mem[i];
    end
    test_reset();
    test_load_word();
    test_store_half();
    test_misalign();
    test_amo_add();
    test_flush();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
